// File: rtl/csync_pkg.sv
// Shared types and timing helpers for the composite-sync generator.
// Tick helpers round to nearest so 102 MHz / 15666 Hz yields a 6511-dot line.
package csync_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      NORMAL = 2'd1,
      VSYNC  = 2'd2
   } seq_state_t;

   function automatic int line_ticks(input real pll, input real hfreq);
      return $rtoi(pll / hfreq + 0.5);
   endfunction

   function automatic int pulse_ticks(input real pll, input real width);
      return $rtoi(pll * width + 0.5);
   endfunction

endpackage

// File: rtl/csync_sequencer_if.sv
// Control inputs and registered sync/timing outputs of the csync sequencer.
// master = controlling side, slave = the sequencer itself.
interface csync_sequencer_if #(
   parameter int DW = 13,
   parameter int LW = 9
);
   logic          enable;
   logic          sync_in;
   logic          csync_n;
   logic          hsync_n;
   logic          vsync_n;
   logic [DW-1:0] dot;
   logic [LW-1:0] line;
   logic          line_start;
   logic          frame_start;
   logic          locked;

   modport master (
      output enable, sync_in,
      input  csync_n, hsync_n, vsync_n, dot, line, line_start, frame_start, locked
   );

   modport slave (
      input  enable, sync_in,
      output csync_n, hsync_n, vsync_n, dot, line, line_start, frame_start, locked
   );
endinterface

// File: rtl/csync_genlock.sv
// External vsync genlock: edge detect, one pending jump request, lock tracking.
// A request raised on a wrap cycle is only honoured at the following wrap.
module csync_genlock (
   input  logic clk,
   input  logic rst,
   input  logic sync_in,
   input  logic dot_wrap,
   input  logic next_line_aligned,
   input  logic running,
   output logic load_vsync,
   output logic locked
);

   logic       r_sync_d;
   logic       r_pending;
   logic       r_locked;
   logic [1:0] r_lock_cnt;
   logic       w_edge;

   assign w_edge     = sync_in && !r_sync_d;
   assign load_vsync = dot_wrap && r_pending;
   assign locked     = r_locked;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync_d   <= 1'b0;
         r_pending  <= 1'b0;
         r_lock_cnt <= 2'd0;
         r_locked   <= 1'b0;
      end else begin
         r_sync_d <= sync_in;
         r_locked <= (r_lock_cnt == 2'd2);
         if (!running) begin
            r_pending  <= 1'b0;
            r_lock_cnt <= 2'd0;
         end else begin
            // While pending, further edges are dropped, including one on the consuming wrap.
            if (r_pending) begin
               if (dot_wrap) begin
                  r_pending <= 1'b0;
               end
            end else if (w_edge) begin
               r_pending <= 1'b1;
            end
            if (load_vsync) begin
               if (!next_line_aligned) begin
                  r_lock_cnt <= 2'd0;
               end else if (r_lock_cnt != 2'd2) begin
                  r_lock_cnt <= r_lock_cnt + 2'd1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/csync_sequencer.sv
// PAL frame timing: dot/line counters, line-type FSM and registered sync outputs.
// Sync outputs and strobes lag the dot/line counters by one clock.
module csync_sequencer
   import csync_pkg::*;
#(
   parameter real PLL_FREQ    = 102.0e6,
   parameter real HSYNC_FREQ  = 15666.0,
   parameter real PULSE_WIDTH = 5.0e-6,
   parameter int  FRAME_LINES = 313,
   parameter int  VSYNC_LINES = 3
) (
   input logic              clk,
   input logic              rst,
   csync_sequencer_if.slave bus
);

   localparam int LINE_TICKS     = line_ticks(PLL_FREQ, HSYNC_FREQ);
   localparam int PULSE_TICKS    = pulse_ticks(PLL_FREQ, PULSE_WIDTH);
   localparam int HSYNC_LOW_DOT  = LINE_TICKS - PULSE_TICKS - 1;
   localparam int HSYNC_HIGH_DOT = LINE_TICKS - 2 * PULSE_TICKS - 1;
   localparam int VSYNC_FIRST    = FRAME_LINES - VSYNC_LINES;
   localparam int DW             = $clog2(LINE_TICKS);
   localparam int LW             = $clog2(FRAME_LINES);

   localparam logic [DW-1:0] DOT_LAST  = DW'(LINE_TICKS - 1);
   localparam logic [DW-1:0] DOT_HLOW  = DW'(HSYNC_LOW_DOT);
   localparam logic [DW-1:0] DOT_HHIGH = DW'(HSYNC_HIGH_DOT);
   localparam logic [LW-1:0] LINE_LAST = LW'(FRAME_LINES - 1);
   localparam logic [LW-1:0] LINE_VSYN = LW'(VSYNC_FIRST);

   seq_state_t    r_state;
   logic [DW-1:0] r_dot;
   logic [LW-1:0] r_line;
   logic          r_csync_n;
   logic          r_hsync_n;
   logic          r_vsync_n;
   logic          r_line_start;
   logic          r_frame_start;

   logic          w_running;
   logic          w_dot_wrap;
   logic          w_last_line;
   logic          w_stop;
   logic          w_next_aligned;
   logic          w_load_vsync;
   logic          w_locked;
   logic          w_in_hsync;
   logic          w_in_serr;
   logic [LW-1:0] w_line_inc;
   logic [LW-1:0] w_line_next;

   assign w_running      = (r_state != IDLE);
   assign w_dot_wrap     = w_running && (r_dot == DOT_LAST);
   assign w_last_line    = (r_line == LINE_LAST);
   assign w_stop         = w_last_line && !bus.enable;
   assign w_line_inc     = w_last_line ? '0 : r_line + 1'b1;
   assign w_next_aligned = (w_line_inc == LINE_VSYN);
   assign w_line_next    = w_load_vsync ? LINE_VSYN : w_line_inc;

   csync_genlock u_genlock (
      .clk               (clk),
      .rst               (rst),
      .sync_in           (bus.sync_in),
      .dot_wrap          (w_dot_wrap),
      .next_line_aligned (w_next_aligned),
      .running           (w_running),
      .load_vsync        (w_load_vsync),
      .locked            (w_locked)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_dot   <= '0;
         r_line  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.enable) begin
                  r_state <= NORMAL;
               end
            end
            default: begin
               if (w_dot_wrap) begin
                  r_dot <= '0;
                  // enable only matters at the end of the frame, so a frame always completes
                  if (w_stop) begin
                     r_state <= IDLE;
                     r_line  <= '0;
                  end else begin
                     r_line  <= w_line_next;
                     r_state <= (w_line_next >= LINE_VSYN) ? VSYNC : NORMAL;
                  end
               end else begin
                  r_dot <= r_dot + 1'b1;
               end
            end
         endcase
      end
   end

   assign w_in_hsync = (r_dot >= DOT_HLOW);
   assign w_in_serr  = (r_dot >= DOT_HHIGH) && (r_dot < DOT_HLOW);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_csync_n     <= 1'b1;
         r_hsync_n     <= 1'b1;
         r_vsync_n     <= 1'b1;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_line_start  <= w_running && (r_dot == '0);
         r_frame_start <= w_running && (r_dot == '0) && (r_line == '0);
         case (r_state)
            NORMAL: begin
               r_csync_n <= !w_in_hsync;
               r_hsync_n <= !w_in_hsync;
               r_vsync_n <= 1'b1;
            end
            VSYNC: begin
               // broad pulses: csync only returns high in the serration window
               r_csync_n <= w_in_serr;
               r_hsync_n <= !w_in_hsync;
               r_vsync_n <= 1'b0;
            end
            default: begin
               r_csync_n <= 1'b1;
               r_hsync_n <= 1'b1;
               r_vsync_n <= 1'b1;
            end
         endcase
      end
   end

   assign bus.csync_n     = r_csync_n;
   assign bus.hsync_n     = r_hsync_n;
   assign bus.vsync_n     = r_vsync_n;
   assign bus.dot         = r_dot;
   assign bus.line        = r_line;
   assign bus.line_start  = r_line_start;
   assign bus.frame_start = r_frame_start;
   assign bus.locked      = w_locked;

endmodule

// File: tb/tb_csync_sequencer.sv
// Directed bench: a scaled-down sequencer (64-dot lines, 20-line frame, 3 vsync lines)
// for frame-level behaviour, plus a default-parameter instance for real line timing.
module tb_csync_sequencer;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   // small: LINE_TICKS=64, PULSE_TICKS=8, HSYNC_LOW_DOT=55, HSYNC_HIGH_DOT=47, VSYNC_FIRST=17
   csync_sequencer_if #(.DW(6), .LW(5)) sif ();
   csync_sequencer_if #(.DW(13), .LW(9)) bif ();

   csync_sequencer #(
      .PLL_FREQ    (64.0),
      .HSYNC_FREQ  (1.0),
      .PULSE_WIDTH (0.125),
      .FRAME_LINES (20),
      .VSYNC_LINES (3)
   ) u_small (
      .clk (clk),
      .rst (rst),
      .bus (sif)
   );

   csync_sequencer u_big (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_small(input int l, input int d, input string tag);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 3000 && !hit; i++) begin
         if (sif.line == l && sif.dot == d) hit = 1'b1;
         else step(1);
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL %s: line %0d dot %0d never reached (now line %0d dot %0d)", tag, l, d, sif.line, sif.dot);
      end
   endtask

   task automatic pulse_at(input int l, input int d);
      wait_small(l, d, "pulse_pos");
      sif.sync_in = 1'b1;
      step(2);
      sif.sync_in = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      sif.enable = 1'b0; sif.sync_in = 1'b0;
      bif.enable = 1'b0; bif.sync_in = 1'b0;
      step(3);
      checks++;
      if ({sif.csync_n, sif.hsync_n, sif.vsync_n} !== 3'b111) begin
         errors++; $display("FAIL reset_sync: got %b want 111", {sif.csync_n, sif.hsync_n, sif.vsync_n});
      end
      checks++;
      if ({sif.line_start, sif.frame_start, sif.locked} !== 3'b000) begin
         errors++; $display("FAIL reset_strobes: got %b want 000", {sif.line_start, sif.frame_start, sif.locked});
      end
      checks++;
      if (sif.dot !== 6'd0 || sif.line !== 5'd0) begin
         errors++; $display("FAIL reset_cnt: dot %0d line %0d want 0 0", sif.dot, sif.line);
      end
      rst = 1'b0;
      step(4);
      checks++;
      if (sif.dot !== 6'd0 || sif.line_start !== 1'b0 || sif.csync_n !== 1'b1) begin
         errors++; $display("FAIL idle_hold: dot %0d ls %b cs %b want 0 0 1", sif.dot, sif.line_start, sif.csync_n);
      end
   endtask

   task automatic test_start();
      int fall, rise, nxt;
      bit hs_ok;
      sif.enable = 1'b1;
      step(1);
      checks++;
      if (sif.line_start !== 1'b0 || sif.dot !== 6'd0) begin
         errors++; $display("FAIL start_cycle1: ls %b dot %0d want 0 0", sif.line_start, sif.dot);
      end
      step(1);
      checks++;
      if (sif.line_start !== 1'b1 || sif.frame_start !== 1'b1 || sif.dot !== 6'd1) begin
         errors++; $display("FAIL start_cycle2: ls %b fs %b dot %0d want 1 1 1", sif.line_start, sif.frame_start, sif.dot);
      end
      fall = -1; rise = -1; nxt = -1; hs_ok = 1'b0;
      for (int c = 1; c <= 200 && nxt < 0; c++) begin
         step(1);
         if (fall < 0 && sif.csync_n === 1'b0) begin
            fall = c;
            hs_ok = (sif.hsync_n === 1'b0) && (sif.vsync_n === 1'b1);
         end
         if (fall >= 0 && rise < 0 && sif.csync_n === 1'b1) rise = c;
         if (sif.line_start === 1'b1) nxt = c;
      end
      checks++;
      if (fall != 55) begin errors++; $display("FAIL small_csync_fall: at %0d want 55", fall); end
      checks++;
      if (rise != 64) begin errors++; $display("FAIL small_csync_rise: at %0d want 64", rise); end
      checks++;
      if (nxt != 64) begin errors++; $display("FAIL small_line_period: %0d want 64", nxt); end
      checks++;
      if (!hs_ok) begin errors++; $display("FAIL small_hsync_match: hsync/vsync %b%b want 01", sif.hsync_n, sif.vsync_n); end
   endtask

   task automatic test_default_timing();
      int fall, rise, nxt;
      bif.enable = 1'b1;
      step(2);
      checks++;
      if (bif.line_start !== 1'b1 || bif.frame_start !== 1'b1) begin
         errors++; $display("FAIL big_first_strobe: ls %b fs %b want 1 1", bif.line_start, bif.frame_start);
      end
      fall = -1; rise = -1; nxt = -1;
      for (int c = 1; c <= 7000 && nxt < 0; c++) begin
         step(1);
         if (fall < 0 && bif.csync_n === 1'b0) fall = c;
         if (fall >= 0 && rise < 0 && bif.csync_n === 1'b1) rise = c;
         if (bif.line_start === 1'b1) nxt = c;
      end
      checks++;
      if (fall != 6000) begin errors++; $display("FAIL big_csync_fall: at %0d want 6000", fall); end
      checks++;
      if (rise - fall != 511) begin errors++; $display("FAIL big_csync_low: %0d cycles want 511", rise - fall); end
      checks++;
      if (nxt != 6511) begin errors++; $display("FAIL big_line_period: %0d want 6511", nxt); end
   endtask

   task automatic test_vsync();
      int period, vs_first, vs_cnt, cs_hi_vs, serr_first, hs_cnt;
      bit got;
      got = 1'b0;
      for (int i = 0; i < 3000 && !got; i++) begin
         if (sif.frame_start === 1'b1) got = 1'b1; else step(1);
      end
      checks++;
      if (!got) begin errors++; $display("FAIL frame_start_seen: none in 3000 cycles"); end
      period = -1; vs_first = -1; vs_cnt = 0; cs_hi_vs = 0; serr_first = -1; hs_cnt = 0;
      for (int c = 1; c <= 2000 && period < 0; c++) begin
         step(1);
         if (sif.vsync_n === 1'b0) begin
            vs_cnt++;
            if (vs_first < 0) vs_first = c;
            if (sif.csync_n === 1'b1) begin
               cs_hi_vs++;
               if (serr_first < 0) serr_first = c;
            end
         end
         if (sif.hsync_n === 1'b0) hs_cnt++;
         if (sif.frame_start === 1'b1) period = c;
      end
      checks++;
      if (period != 1280) begin errors++; $display("FAIL frame_period: %0d want 1280", period); end
      checks++;
      if (vs_first != 1088) begin errors++; $display("FAIL vsync_first: at %0d want 1088", vs_first); end
      checks++;
      if (vs_cnt != 192) begin errors++; $display("FAIL vsync_len: %0d want 192", vs_cnt); end
      checks++;
      if (cs_hi_vs != 24) begin errors++; $display("FAIL serration_len: %0d want 24", cs_hi_vs); end
      checks++;
      if (serr_first != 1135) begin errors++; $display("FAIL serration_pos: at %0d want 1135", serr_first); end
      checks++;
      if (hs_cnt != 180) begin errors++; $display("FAIL hsync_count: %0d want 180", hs_cnt); end
   endtask

   task automatic test_disable();
      int stray;
      wait_small(5, 10, "disable_pos");
      sif.enable = 1'b0;
      wait_small(19, 63, "frame_end");
      step(1);
      checks++;
      if (sif.dot !== 6'd0 || sif.line !== 5'd0 || sif.vsync_n !== 1'b0) begin
         errors++; $display("FAIL idle_entry: dot %0d line %0d vs %b want 0 0 0", sif.dot, sif.line, sif.vsync_n);
      end
      step(1);
      checks++;
      if ({sif.csync_n, sif.hsync_n, sif.vsync_n, sif.line_start} !== 4'b1110) begin
         errors++; $display("FAIL idle_outputs: got %b want 1110", {sif.csync_n, sif.hsync_n, sif.vsync_n, sif.line_start});
      end
      stray = 0;
      for (int c = 0; c < 70; c++) begin
         step(1);
         if (sif.line_start !== 1'b0 || sif.dot !== 6'd0) stray++;
      end
      checks++;
      if (stray != 0) begin errors++; $display("FAIL idle_stays: %0d active cycles want 0", stray); end
   endtask

   task automatic test_genlock();
      sif.enable = 1'b1;
      step(2);
      pulse_at(5, 20);
      wait_small(5, 63, "jump_wrap");
      step(1);
      checks++;
      if (sif.line !== 5'd17 || sif.dot !== 6'd0) begin
         errors++; $display("FAIL genlock_jump: line %0d dot %0d want 17 0", sif.line, sif.dot);
      end
      step(1);
      checks++;
      if (sif.vsync_n !== 1'b0 || sif.locked !== 1'b0) begin
         errors++; $display("FAIL jump_vsync_lock: vs %b locked %b want 0 0", sif.vsync_n, sif.locked);
      end
      pulse_at(16, 20);
      wait_small(17, 2, "aligned1");
      checks++;
      if (sif.locked !== 1'b0) begin errors++; $display("FAIL lock_one_frame: locked %b want 0", sif.locked); end
      pulse_at(16, 20);
      wait_small(17, 2, "aligned2");
      checks++;
      if (sif.locked !== 1'b1) begin errors++; $display("FAIL lock_two_frames: locked %b want 1", sif.locked); end
      pulse_at(5, 20);
      wait_small(5, 63, "misaligned_wrap");
      step(3);
      checks++;
      if (sif.line !== 5'd17 || sif.locked !== 1'b0) begin
         errors++; $display("FAIL unlock: line %0d locked %b want 17 0", sif.line, sif.locked);
      end
   endtask

   task automatic test_wrap_edge();
      wait_small(8, 63, "wrap_edge_pos");
      sif.sync_in = 1'b1;
      step(1);
      checks++;
      if (sif.line !== 5'd9) begin errors++; $display("FAIL wrap_edge_deferred: line %0d want 9", sif.line); end
      sif.sync_in = 1'b0;
      wait_small(9, 63, "pending_wrap");
      sif.sync_in = 1'b1;
      step(1);
      checks++;
      if (sif.line !== 5'd17) begin errors++; $display("FAIL deferred_jump: line %0d want 17", sif.line); end
      sif.sync_in = 1'b0;
      wait_small(17, 63, "after_jump");
      step(1);
      checks++;
      if (sif.line !== 5'd18 || sif.locked !== 1'b0) begin
         errors++; $display("FAIL edge_while_pending: line %0d locked %b want 18 0", sif.line, sif.locked);
      end
   endtask

   task automatic test_reset_mid();
      pulse_at(16, 20);
      wait_small(17, 2, "relock1");
      pulse_at(16, 20);
      wait_small(17, 2, "relock2");
      checks++;
      if (sif.locked !== 1'b1) begin errors++; $display("FAIL relock: locked %b want 1", sif.locked); end
      wait_small(18, 30, "reset_pos");
      rst = 1'b1;
      step(1);
      checks++;
      if ({sif.csync_n, sif.hsync_n, sif.vsync_n, sif.line_start, sif.frame_start, sif.locked} !== 6'b111000) begin
         errors++; $display("FAIL mid_reset_out: got %b want 111000",
                            {sif.csync_n, sif.hsync_n, sif.vsync_n, sif.line_start, sif.frame_start, sif.locked});
      end
      checks++;
      if (sif.dot !== 6'd0 || sif.line !== 5'd0) begin
         errors++; $display("FAIL mid_reset_cnt: dot %0d line %0d want 0 0", sif.dot, sif.line);
      end
      sif.enable = 1'b0;
      rst = 1'b0;
      step(3);
      checks++;
      if (sif.dot !== 6'd0 || sif.csync_n !== 1'b1) begin
         errors++; $display("FAIL post_reset_idle: dot %0d cs %b want 0 1", sif.dot, sif.csync_n);
      end
   endtask

   initial begin
      test_reset();
      test_start();
      test_default_timing();
      test_vsync();
      test_disable();
      test_genlock();
      test_wrap_edge();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
